// File: rtl/touch_adc_ctrl_if.sv
// touch_adc_ctrl_if: pin bundle between the touch controller (master) and the ADS7843-class ADC (slave).
interface touch_adc_ctrl_if;
  logic adc_dclk, adc_cs_n, adc_din, adc_dout, adc_penirq_n, adc_busy;
  modport master (output adc_dclk, adc_cs_n, adc_din, input adc_dout, adc_penirq_n, adc_busy);
  modport slave (input adc_dclk, adc_cs_n, adc_din, output adc_dout, adc_penirq_n, adc_busy);
endinterface

// File: rtl/touch_adc_ctrl.sv
// touch_adc_ctrl: SPI master for the resistive-touch ADC; debounces pen-down, converts X/Y, publishes coordinates.
// Define TOUCH_AVG_EN to average four back-to-back X/Y pairs per frame.
module touch_adc_ctrl #(
  parameter int CLK_DIV  = 25,
  parameter int DEBOUNCE = 1000,
  parameter int GAP      = 50000
) (
  input  logic             sys_clk,
  input  logic             iRST_n,
  touch_adc_ctrl_if.master adc,
  output logic [7:0]       x_out,
  output logic [9:0]       y_out,
  output logic             new_coord,
  output logic             transmit_en,
  output logic             penirq_n
);
  localparam int DW = $clog2(CLK_DIV + 1);
  localparam int BW = $clog2(DEBOUNCE + 1);
  localparam int GW = $clog2(GAP + 1);
  typedef enum logic [2:0] {IDLE, CONV_X, CONV_Y, PUBLISH, WAIT_GAP} state_t;
  state_t state, state_n;
  logic pen_s1, pen_s2, dout_s1, dout_s2;
  logic [DW-1:0] div, div_n;
  logic [5:0] half, half_n;
  logic [BW-1:0] deb, deb_n;
  logic [GW-1:0] gcnt, gcnt_n;
  logic [11:0] shreg, shreg_n;
  logic [4:0] idx;
  logic [7:0] cmd;
  logic conv, conv_n, term, axis_done, last_pair, dclk_n, din_n;
`ifdef TOUCH_AVG_EN
  logic [1:0] pair;
  logic [13:0] xsum, ysum;
  assign last_pair = pair == 2'd3;
`else
  logic [7:0] xr;
  assign last_pair = 1'b1;
`endif
  always_comb begin
    conv = state == CONV_X || state == CONV_Y;
    term = conv && div == DW'(CLK_DIV - 1);
    axis_done = term && half == 6'd47;
    div_n = term || !conv ? '0 : div + 1'b1;
    half_n = axis_done || !conv ? '0 : half + 6'(term);
    dclk_n = conv && (adc.adc_dclk ^ term);
    // result bits ride DCLK rises 10..21 of each axis
    shreg_n = term && !adc.adc_dclk && half[5:1] >= 5'd9 && half[5:1] <= 5'd20 ? {shreg[10:0], dout_s2} : shreg;
    deb_n = state == IDLE && !pen_s2 ? deb + 1'b1 : '0;
    gcnt_n = state == WAIT_GAP ? gcnt + 1'b1 : '0;
    state_n = state;
    case (state)
      IDLE:     state_n = !pen_s2 && deb == BW'(DEBOUNCE - 1) ? CONV_X : IDLE;
      CONV_X:   state_n = axis_done ? CONV_Y : CONV_X;
      CONV_Y:   state_n = axis_done ? (last_pair ? PUBLISH : CONV_X) : CONV_Y;
      PUBLISH:  state_n = WAIT_GAP;
      WAIT_GAP: state_n = gcnt == GW'(GAP - 1) ? (pen_s2 ? IDLE : CONV_X) : WAIT_GAP;
      default:  state_n = IDLE;
    endcase
    conv_n = state_n == CONV_X || state_n == CONV_Y;
    idx = half_n[5:1];
    cmd = state_n == CONV_Y ? 8'h90 : 8'hD0;
    // din only moves when the next half-period is a low one
    din_n = conv_n && (half_n[0] ? adc.adc_din : idx < 5'd8 && cmd[~idx[2:0]]);
  end
  always_ff @(posedge sys_clk or negedge iRST_n) begin
    if (!iRST_n) begin
      state <= IDLE;
      {pen_s1, pen_s2, dout_s1, dout_s2} <= 4'b1100;
      div <= '0;
      half <= '0;
      deb <= '0;
      gcnt <= '0;
      shreg <= '0;
      adc.adc_dclk <= 1'b0;
      adc.adc_cs_n <= 1'b1;
      adc.adc_din <= 1'b0;
      x_out <= '0;
      y_out <= '0;
      new_coord <= 1'b0;
      transmit_en <= 1'b0;
      penirq_n <= 1'b1;
`ifdef TOUCH_AVG_EN
      pair <= '0;
      xsum <= '0;
      ysum <= '0;
`else
      xr <= '0;
`endif
    end else begin
      {pen_s1, pen_s2, dout_s1, dout_s2} <= {adc.adc_penirq_n, pen_s1, adc.adc_dout, dout_s1};
      state <= state_n;
      div <= div_n;
      half <= half_n;
      deb <= deb_n;
      gcnt <= gcnt_n;
      shreg <= shreg_n;
      adc.adc_dclk <= dclk_n;
      adc.adc_cs_n <= !conv_n;
      adc.adc_din <= din_n;
      new_coord <= state == PUBLISH;
      if (state == IDLE && state_n == CONV_X) begin
        transmit_en <= 1'b1;
        penirq_n <= 1'b0;
      end
      if (state == WAIT_GAP && state_n == IDLE) begin
        transmit_en <= 1'b0;
        penirq_n <= 1'b1;
      end
`ifdef TOUCH_AVG_EN
      if (conv_n && !conv) begin
        pair <= '0;
        xsum <= '0;
        ysum <= '0;
      end
      if (axis_done && state == CONV_X) xsum <= xsum + 14'(shreg);
      if (axis_done && state == CONV_Y) begin
        ysum <= ysum + 14'(shreg);
        pair <= pair + 1'b1;
      end
      if (state == PUBLISH) begin
        x_out <= xsum[13:6];
        y_out <= ysum[13:4];
      end
`else
      if (axis_done && state == CONV_X) xr <= shreg[11:4];
      if (state == PUBLISH) begin
        x_out <= xr;
        y_out <= shreg[11:2];
      end
`endif
    end
  end
endmodule

// File: tb/tb_touch_adc_ctrl.sv
// tb_touch_adc_ctrl: directed bench for touch_adc_ctrl with a behavioural ADS7843 model and SPI protocol checks.
module tb_touch_adc_ctrl;
  localparam int CLK_DIV = 25, DEBOUNCE = 20, GAP = 300;
`ifdef TOUCH_AVG_EN
  localparam int NP = 4;
  localparam logic [7:0] XE = 8'h10;
`else
  localparam int NP = 1;
  localparam logic [7:0] XE = 8'hA5;
`endif
  localparam logic [9:0] YE = 10'h0FE;
  localparam int LAT = NP * 96 * CLK_DIV + 1;
  logic sys_clk = 1'b0, iRST_n = 1'b0;
  logic [7:0] x_out;
  logic [9:0] y_out;
  logic new_coord, transmit_en, penirq_n;
  int total = 0, bad = 0, cyc = 0, strobes = 0, cs_falls = 0, rtot = 0, xi = 0, busy_cyc = 0;
  logic [7:0] cmd_sh = '0;
  logic [11:0] cur = '0;
  logic din_q = 1'b0, cs_q = 1'b1;
  touch_adc_ctrl_if ad();
  touch_adc_ctrl #(.CLK_DIV(CLK_DIV), .DEBOUNCE(DEBOUNCE), .GAP(GAP)) dut (
    .sys_clk(sys_clk), .iRST_n(iRST_n), .adc(ad.master), .x_out(x_out), .y_out(y_out),
    .new_coord(new_coord), .transmit_en(transmit_en), .penirq_n(penirq_n));
  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc++;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic check_range(input string tag, input int obs, input int lo, input int hi);
    total++;
    assert (obs >= lo && obs <= hi) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask
  function automatic logic [11:0] x_val(input int i);
`ifdef TOUCH_AVG_EN
    return 12'h100 + 12'(4 * i);
`else
    return 12'hA5C + 12'(0 * i);
`endif
  endfunction
  always @(negedge sys_clk) begin
    din_q = ad.adc_din;
    cs_q = ad.adc_cs_n;
    if (ad.adc_busy === 1'b1) busy_cyc++;
    if (new_coord === 1'b1) begin
      strobes++;
      check("strobe_needs_te", transmit_en, 1);
    end
  end
  always @(posedge ad.adc_dclk or negedge ad.adc_dclk) if (iRST_n) check("dclk_with_cs", cs_q, 0);
  always @(negedge ad.adc_cs_n) begin
    rtot = 0;
    xi = 0;
    cs_falls++;
  end
  always @(posedge ad.adc_cs_n) if (iRST_n) check("rises_per_frame", rtot, NP * 48);
  // ADC model: command captured on rises 1..8, result driven MSB first after rise 9
  always @(posedge ad.adc_dclk) if (iRST_n) begin
    check("din_stable", ad.adc_din, din_q);
    if (rtot % 24 < 8) cmd_sh = {cmd_sh[6:0], ad.adc_din};
    if (rtot % 24 == 7) check("cmd_byte", cmd_sh, ((rtot / 24) % 2 == 1) ? 8'h90 : 8'hD0);
    rtot++;
  end
  always @(negedge ad.adc_dclk) if (iRST_n && rtot > 0) begin
    automatic int r = (rtot - 1) % 24 + 1;
    automatic bit is_y = ((rtot - 1) / 24) % 2 == 1;
    if (r == 9) cur = is_y ? 12'h3F8 : x_val(xi);
    ad.adc_dout = (r >= 9 && r <= 20) ? cur[20 - r] : 1'b0;
    ad.adc_busy = r == 8;
    if (r == 24 && !is_y) xi++;
  end
  initial begin
    int n, t0, t1, tf1, tf2;
    ad.adc_penirq_n = 1'b1;
    repeat (3) @(negedge sys_clk);
    check("rst_cs_n", ad.adc_cs_n, 1);
    check("rst_dclk", ad.adc_dclk, 0);
    check("rst_din", ad.adc_din, 0);
    check("rst_x", x_out, 0);
    check("rst_y", y_out, 0);
    check("rst_new_coord", new_coord, 0);
    check("rst_te", transmit_en, 0);
    check("rst_penirq_n", penirq_n, 1);
    iRST_n = 1'b1;
    repeat (5) @(negedge sys_clk);
    repeat (4) begin
      ad.adc_penirq_n = 1'b0;
      repeat (DEBOUNCE - 1) @(negedge sys_clk);
      ad.adc_penirq_n = 1'b1;
      @(negedge sys_clk);
    end
    repeat (10) @(negedge sys_clk);
    check("glitch_cs_falls", cs_falls, 0);
    check("glitch_te", transmit_en, 0);
    check("glitch_penirq_n", penirq_n, 1);
    ad.adc_penirq_n = 1'b0;
    t0 = cyc;
    n = 0;
    while (ad.adc_cs_n !== 1'b0 && n < DEBOUNCE + 20) begin @(negedge sys_clk); n++; end
    check_range("pen_to_cs", cyc - t0, DEBOUNCE + 2, DEBOUNCE + 3);
    check("start_te", transmit_en, 1);
    check("start_penirq_n", penirq_n, 0);
    tf1 = cyc;
    n = 0;
    while (new_coord !== 1'b1 && n < LAT + 100) begin @(negedge sys_clk); n++; end
    check("frame_latency", cyc - tf1, LAT);
    check("f1_x", x_out, XE);
    check("f1_y", y_out, YE);
    check("f1_cs_high", ad.adc_cs_n, 1);
    @(negedge sys_clk);
    check("strobe_width", new_coord, 0);
    n = 0;
    while (ad.adc_cs_n !== 1'b0 && n < GAP + 100) begin @(negedge sys_clk); n++; end
    tf2 = cyc;
    check("frame_period", tf2 - tf1, LAT + GAP);
    n = 0;
    while (new_coord !== 1'b1 && n < LAT + 100) begin @(negedge sys_clk); n++; end
    check("f2_strobe", new_coord, 1);
    n = 0;
    while (ad.adc_cs_n !== 1'b0 && n < GAP + 100) begin @(negedge sys_clk); n++; end
    repeat (500) @(negedge sys_clk);
    ad.adc_penirq_n = 1'b1;
    n = 0;
    while (new_coord !== 1'b1 && n < LAT + 100) begin @(negedge sys_clk); n++; end
    t1 = cyc;
    check("f3_x", x_out, XE);
    check("f3_y", y_out, YE);
    check("f3_te_held", transmit_en, 1);
    n = 0;
    while (transmit_en !== 1'b0 && n < GAP + 100) begin @(negedge sys_clk); n++; end
    check("te_fall_delay", cyc - t1, GAP);
    check("release_penirq_n", penirq_n, 1);
    repeat (200) @(negedge sys_clk);
    check("strobe_count", strobes, 3);
    check("frame_count", cs_falls, 3);
    check("idle_cs_n", ad.adc_cs_n, 1);
    ad.adc_penirq_n = 1'b0;
    n = 0;
    while (ad.adc_cs_n !== 1'b0 && n < DEBOUNCE + 20) begin @(negedge sys_clk); n++; end
    n = 0;
    while (rtot < 24 + 15 && n < LAT + 100) begin @(negedge sys_clk); n++; end
    check("abort_at_y15", rtot, 39);
    #2 iRST_n = 1'b0;
    #1;
    check("abort_cs_n", ad.adc_cs_n, 1);
    check("abort_dclk", ad.adc_dclk, 0);
    check("abort_x", x_out, 0);
    check("abort_y", y_out, 0);
    check("abort_te", transmit_en, 0);
    check("abort_penirq_n", penirq_n, 1);
    repeat (2) @(negedge sys_clk);
    iRST_n = 1'b1;
    t0 = cyc;
    n = 0;
    while (ad.adc_cs_n !== 1'b0 && n < DEBOUNCE + 20) begin @(negedge sys_clk); n++; end
    check_range("restart_debounce", cyc - t0, DEBOUNCE + 2, DEBOUNCE + 3);
    n = 0;
    while (new_coord !== 1'b1 && n < LAT + 100) begin @(negedge sys_clk); n++; end
    check("f4_x", x_out, XE);
    check("f4_y", y_out, YE);
    ad.adc_penirq_n = 1'b1;
    n = 0;
    while (transmit_en !== 1'b0 && n < GAP + 100) begin @(negedge sys_clk); n++; end
    check("final_te", transmit_en, 0);
    $display("adc busy slots seen: %0d", busy_cyc);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
